// File: rtl/stage_decision.sv
// stage_decision: per-window cascade sequencer sitting behind the stage-sum
// accumulator. It fetches each stage's config, watches the weak-classifier
// results arrive, compares the final fp32 sum against the stage threshold and
// either advances to the next stage or reports the window verdict.
// Optional statistics counters are enabled by defining STAGE_DECISION_STATS_EN.
module stage_decision #(
    parameter int NUM_STAGES = 25,
    parameter int LEN_W      = 9,
    parameter int IDX_W      = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             window_start_i,
    input  logic             window_abort_i,
    output logic             cfg_req_o,
    input  logic             cfg_val_i,
    input  logic [31:0]      cfg_threshold_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic [31:0]      stage_sum_i,
    input  logic             stage_sum_val_i,
    output logic             new_stage_o,
    output logic [IDX_W-1:0] stage_idx_o,
    output logic             busy_o,
    output logic             window_done_o,
    output logic             window_pass_o,
    output logic [IDX_W-1:0] reject_stage_o
`ifdef STAGE_DECISION_STATS_EN
    ,
    output logic [31:0]      stat_windows_o,
    output logic [31:0]      stat_passed_o,
    output logic [15:0]      stat_stray_o
`endif
);

    typedef enum logic [1:0] {IDLE, CFG, ACCUM, CMP} state_t;

    localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(NUM_STAGES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] stageIdx_q, stageIdx_d;
    logic [31:0]      threshold_q, threshold_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      sum_q, sum_d;
    logic [LEN_W-1:0] weakCnt_q, weakCnt_d;
    logic             newStage_q, newStage_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [IDX_W-1:0] reject_q, reject_d;
    logic             stagePass;

    // Map an fp32 value onto an unsigned key whose ordering matches the real
    // ordering; both zeros are folded onto +0.0 first so that -0.0 == +0.0.
    function automatic logic [31:0] fpKey(input logic [31:0] value);
        logic [31:0] norm;
        norm = (value[30:0] == 31'd0) ? 32'd0 : value;
        return norm[31] ? ~norm : (norm | 32'h8000_0000);
    endfunction

    // Stage verdict: running sum compared against the captured threshold.
    always_comb begin
        stagePass = (fpKey(sum_q) >= fpKey(threshold_q));
    end

    // Next-state and datapath updates; abort overrides every other event.
    always_comb begin
        state_d     = state_q;
        stageIdx_d  = stageIdx_q;
        threshold_d = threshold_q;
        len_d       = len_q;
        sum_d       = sum_q;
        weakCnt_d   = weakCnt_q;
        newStage_d  = 1'b0;
        done_d      = 1'b0;
        pass_d      = pass_q;
        reject_d    = reject_q;
        if (window_abort_i) begin
            state_d    = IDLE;
            stageIdx_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (window_start_i) begin
                        stageIdx_d = '0;
                        state_d    = CFG;
                    end
                end
                CFG: begin
                    if (cfg_val_i) begin
                        threshold_d = cfg_threshold_i;
                        len_d       = cfg_len_i;
                        weakCnt_d   = '0;
                        sum_d       = 32'd0;
                        newStage_d  = 1'b1;
                        state_d     = (cfg_len_i == '0) ? CMP : ACCUM;
                    end
                end
                ACCUM: begin
                    if (stage_sum_val_i) begin
                        sum_d     = stage_sum_i;
                        weakCnt_d = weakCnt_q + LEN_W'(1);
                        if (weakCnt_q == len_q - LEN_W'(1)) begin
                            state_d = CMP;
                        end
                    end
                end
                CMP: begin
                    if (!stagePass) begin
                        done_d   = 1'b1;
                        pass_d   = 1'b0;
                        reject_d = stageIdx_q;
                        state_d  = IDLE;
                    end else if (stageIdx_q == LAST_STAGE) begin
                        done_d   = 1'b1;
                        pass_d   = 1'b1;
                        reject_d = '0;
                        state_d  = IDLE;
                    end else begin
                        stageIdx_d = stageIdx_q + IDX_W'(1);
                        state_d    = CFG;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            stageIdx_q  <= '0;
            threshold_q <= 32'd0;
            len_q       <= '0;
            sum_q       <= 32'd0;
            weakCnt_q   <= '0;
            newStage_q  <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            reject_q    <= '0;
        end else begin
            state_q     <= state_d;
            stageIdx_q  <= stageIdx_d;
            threshold_q <= threshold_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            weakCnt_q   <= weakCnt_d;
            newStage_q  <= newStage_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            reject_q    <= reject_d;
        end
    end

    // Output drive: request and busy follow the state, the rest are registered.
    always_comb begin
        cfg_req_o      = (state_q == CFG);
        busy_o         = (state_q != IDLE);
        new_stage_o    = newStage_q;
        stage_idx_o    = stageIdx_q;
        window_done_o  = done_q;
        window_pass_o  = pass_q;
        reject_stage_o = reject_q;
    end

`ifdef STAGE_DECISION_STATS_EN
    logic [31:0] statWindows_q;
    logic [31:0] statPassed_q;
    logic [15:0] statStray_q;

    // Saturating statistics: verdicts, accepted windows and stray results.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            statWindows_q <= '0;
            statPassed_q  <= '0;
            statStray_q   <= '0;
        end else begin
            if (done_q && statWindows_q != '1) begin
                statWindows_q <= statWindows_q + 32'd1;
            end
            if (done_q && pass_q && statPassed_q != '1) begin
                statPassed_q <= statPassed_q + 32'd1;
            end
            if (stage_sum_val_i && state_q != ACCUM && statStray_q != '1) begin
                statStray_q <= statStray_q + 16'd1;
            end
        end
    end

    assign stat_windows_o = statWindows_q;
    assign stat_passed_o  = statPassed_q;
    assign stat_stray_o   = statStray_q;
`endif

endmodule

// File: tb/tb_stage_decision.sv
// tb_stage_decision: directed bench for stage_decision with a two-stage cascade.
// Window verdicts are queued when a window is launched and matched against
// every window_done_o pulse seen by the monitor.
module tb_stage_decision;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        window_start_i;
    logic        window_abort_i;
    logic        cfg_req_o;
    logic        cfg_val_i;
    logic [31:0] cfg_threshold_i;
    logic [8:0]  cfg_len_i;
    logic [31:0] stage_sum_i;
    logic        stage_sum_val_i;
    logic        new_stage_o;
    logic [4:0]  stage_idx_o;
    logic        busy_o;
    logic        window_done_o;
    logic        window_pass_o;
    logic [4:0]  reject_stage_o;
`ifdef STAGE_DECISION_STATS_EN
    logic [31:0] stat_windows_o;
    logic [31:0] stat_passed_o;
    logic [15:0] stat_stray_o;
`endif

    typedef struct packed {
        logic       pass;
        logic [4:0] rej;
    } verdict_t;

    verdict_t expQ[$];
    int compared   = 0;
    int mismatched = 0;
    int expWin     = 0;
    int expPass    = 0;

    always #5 clk = ~clk;

    stage_decision #(.NUM_STAGES(2), .LEN_W(9), .IDX_W(5)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .window_start_i  (window_start_i),
        .window_abort_i  (window_abort_i),
        .cfg_req_o       (cfg_req_o),
        .cfg_val_i       (cfg_val_i),
        .cfg_threshold_i (cfg_threshold_i),
        .cfg_len_i       (cfg_len_i),
        .stage_sum_i     (stage_sum_i),
        .stage_sum_val_i (stage_sum_val_i),
        .new_stage_o     (new_stage_o),
        .stage_idx_o     (stage_idx_o),
        .busy_o          (busy_o),
        .window_done_o   (window_done_o),
        .window_pass_o   (window_pass_o),
        .reject_stage_o  (reject_stage_o)
`ifdef STAGE_DECISION_STATS_EN
        ,
        .stat_windows_o  (stat_windows_o),
        .stat_passed_o   (stat_passed_o),
        .stat_stray_o    (stat_stray_o)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitCycle();
        @(negedge clk);
    endtask

    task automatic pushVerdict(input logic pass, input logic [4:0] rej);
        verdict_t v;
        v.pass = pass;
        v.rej  = rej;
        expQ.push_back(v);
        expWin++;
        if (pass) expPass++;
    endtask

    task automatic startWindow();
        window_start_i = 1'b1;
        waitCycle();
        window_start_i = 1'b0;
    endtask

    task automatic waitCfgReq();
        int n = 0;
        while (cfg_req_o !== 1'b1 && n < 20) begin
            waitCycle();
            n++;
        end
        if (n == 20) checkOutput("cfg_req_timeout", cfg_req_o, 1);
    endtask

    // One full stage: config handshake, then len results with finalSum last.
    // Returns at the negedge where the DUT sits in the compare cycle.
    task automatic applyStimulus(input logic [31:0] thr, input logic [8:0] len, input logic [31:0] finalSum);
        waitCfgReq();
        cfg_val_i       = 1'b1;
        cfg_threshold_i = thr;
        cfg_len_i       = len;
        waitCycle();
        cfg_val_i = 1'b0;
        checkOutput("new_stage_pulse", new_stage_o, 1);
        for (int i = 0; i < int'(len); i++) begin
            stage_sum_i     = (i == int'(len) - 1) ? finalSum : 32'h3f00_0000;
            stage_sum_val_i = 1'b1;
            waitCycle();
        end
        stage_sum_val_i = 1'b0;
    endtask

    // Scoreboard side: every verdict pulse must match the oldest queued entry.
    always @(negedge clk) begin
        if (rst_i === 1'b1 && window_done_o === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", window_done_o, 0);
            end else begin
                verdict_t e;
                e = expQ.pop_front();
                checkOutput("verdict_pass", window_pass_o, e.pass);
                if (!e.pass) checkOutput("verdict_reject", reject_stage_o, e.rej);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i           = 1'b0;
        window_start_i  = 1'b0;
        window_abort_i  = 1'b0;
        cfg_val_i       = 1'b0;
        cfg_threshold_i = 32'd0;
        cfg_len_i       = 9'd0;
        stage_sum_i     = 32'd0;
        stage_sum_val_i = 1'b0;
        waitCycle();
        waitCycle();
        checkOutput("reset_busy", busy_o, 0);
        checkOutput("reset_cfg_req", cfg_req_o, 0);
        checkOutput("reset_done", window_done_o, 0);
        checkOutput("reset_stage_idx", stage_idx_o, 0);
        rst_i = 1'b1;
        waitCycle();

        $display("[TB] reset in the middle of a stage");
        startWindow();
        waitCfgReq();
        cfg_val_i = 1'b1; cfg_threshold_i = 32'h3f80_0000; cfg_len_i = 9'd4;
        waitCycle();
        cfg_val_i = 1'b0;
        stage_sum_val_i = 1'b1; stage_sum_i = 32'h3f00_0000;
        waitCycle();
        waitCycle();
        stage_sum_val_i = 1'b0;
        checkOutput("accum_busy", busy_o, 1);
        rst_i = 1'b0;
        waitCycle();
        checkOutput("midreset_busy", busy_o, 0);
        checkOutput("midreset_new_stage", new_stage_o, 0);
        checkOutput("midreset_pass", window_pass_o, 0);
        checkOutput("midreset_reject", reject_stage_o, 0);
        rst_i = 1'b1;
        waitCycle();
        waitCycle();

        $display("[TB] two-stage window accepted");
        startWindow();
        pushVerdict(1'b1, 5'd0);
        applyStimulus(32'h3f80_0000, 9'd3, 32'h3fc0_0000);
        waitCycle();
        checkOutput("stage1_cfg_req_latency", cfg_req_o, 1);
        checkOutput("stage1_idx", stage_idx_o, 1);
        window_start_i = 1'b1;
        waitCycle();
        window_start_i = 1'b0;
        checkOutput("start_while_busy_idx", stage_idx_o, 1);
        applyStimulus(32'h4000_0000, 9'd2, 32'h4020_0000);
        checkOutput("done_not_early", window_done_o, 0);
        waitCycle();
        checkOutput("done_latency", window_done_o, 1);
        waitCycle();
        checkOutput("done_is_pulse", window_done_o, 0);
        checkOutput("pass_holds", window_pass_o, 1);

        $display("[TB] stage 0 rejection");
        startWindow();
        pushVerdict(1'b0, 5'd0);
        applyStimulus(32'h3f00_0000, 9'd4, 32'h3e80_0000);
        waitCycle();
        checkOutput("reject_done", window_done_o, 1);
        checkOutput("reject_no_cfg_req", cfg_req_o, 0);
        waitCycle();
        checkOutput("reject_idle", busy_o, 0);
        checkOutput("reject_still_no_cfg_req", cfg_req_o, 0);

        $display("[TB] signed and zero compares");
        startWindow();
        pushVerdict(1'b1, 5'd0);
        applyStimulus(32'h0000_0000, 9'd1, 32'h8000_0000);
        waitCycle();
        checkOutput("neg_zero_passes", stage_idx_o, 1);
        applyStimulus(32'hc000_0000, 9'd2, 32'hbf80_0000);
        waitCycle();
        waitCycle();
        startWindow();
        pushVerdict(1'b0, 5'd1);
        applyStimulus(32'hc000_0000, 9'd1, 32'hbf80_0000);
        waitCycle();
        applyStimulus(32'hbf80_0000, 9'd3, 32'hc000_0000);
        waitCycle();
        checkOutput("neg_reject_done", window_done_o, 1);
        waitCycle();

        $display("[TB] abort on the last result");
        startWindow();
        applyStimulus(32'h3f80_0000, 9'd1, 32'h3fc0_0000);
        waitCycle();
        waitCfgReq();
        cfg_val_i = 1'b1; cfg_threshold_i = 32'h3f80_0000; cfg_len_i = 9'd2;
        waitCycle();
        cfg_val_i = 1'b0;
        stage_sum_val_i = 1'b1; stage_sum_i = 32'h4000_0000;
        waitCycle();
        window_abort_i = 1'b1;
        waitCycle();
        window_abort_i = 1'b0;
        stage_sum_val_i = 1'b0;
        checkOutput("abort_busy", busy_o, 0);
        checkOutput("abort_stage_idx", stage_idx_o, 0);
        checkOutput("abort_no_done", window_done_o, 0);
        waitCycle();
        checkOutput("abort_no_done_later", window_done_o, 0);

        $display("[TB] zero-length stages and cfg during start");
        window_start_i = 1'b1;
        cfg_val_i = 1'b1; cfg_threshold_i = 32'h3f80_0000; cfg_len_i = 9'd0;
        waitCycle();
        window_start_i = 1'b0;
        cfg_val_i = 1'b0;
        checkOutput("restart_cfg_req", cfg_req_o, 1);
        checkOutput("restart_stage_idx", stage_idx_o, 0);
        checkOutput("start_cfg_ignored", new_stage_o, 0);
        pushVerdict(1'b0, 5'd1);
        applyStimulus(32'hbf80_0000, 9'd0, 32'd0);
        waitCycle();
        checkOutput("len0_neg_thr_passes", stage_idx_o, 1);
        applyStimulus(32'h3f80_0000, 9'd0, 32'd0);
        waitCycle();
        checkOutput("len0_pos_thr_done", window_done_o, 1);
        waitCycle();

`ifdef STAGE_DECISION_STATS_EN
        for (int i = 0; i < 3; i++) begin
            stage_sum_val_i = 1'b1;
            waitCycle();
            stage_sum_val_i = 1'b0;
            waitCycle();
        end
        waitCycle();
        checkOutput("stat_stray", stat_stray_o, 3);
        checkOutput("stat_windows", stat_windows_o, expWin);
        checkOutput("stat_passed", stat_passed_o, expPass);
`endif

        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
